// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned UART_BAUD_RATE  = 1500000;
  localparam int unsigned UART_CLOCK_FREQ = 10000000;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_SEND  = 3'd3,
    ST_HOLD  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART start/ready handshake.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_tx_start;
  logic [BYTE_W-1:0]         uart_transmit_data;
  logic                      uart_tx_ready;

  // Environment side: requesters and the UART transmitter.
  modport master (
    output req_valid, req_data, req_last, uart_tx_ready,
    input  req_ready, uart_tx_start, uart_transmit_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, uart_tx_ready,
    output req_ready, uart_tx_start, uart_transmit_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_grant_c,
  output logic               o_any_c
);

  localparam logic [IDX_W:0] NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);

  // Scan NUM_REQ positions starting at i_ptr; modulo by subtraction so any NUM_REQ works.
  always_comb begin
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    o_grant_c = '0;
    o_any_c   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NUM_REQ_EXT) begin
        w_sum = w_sum - NUM_REQ_EXT;
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_any_c && i_req[w_idx]) begin
        o_grant_c = w_idx;
        o_any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned ACK_TIMEOUT = 64,
  localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk_10ns,
  input  logic                 uart_reset,
  uart_tx_arbiter_if.slave     bus,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned      WD_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(ACK_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);
  localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(NUM_REQ - 1);

  arb_state_e           r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant;
  logic [BYTE_W-1:0]    r_byte;
  logic                 r_last;
  logic [WD_W-1:0]      r_wd;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_timeout;

  logic [IDX_W-1:0]     w_pick;
  logic                 w_any;
  logic [IDX_W-1:0]     w_ptr_next;
  logic [BYTE_W-1:0]    w_sel_byte;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req     (bus.req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_pick),
    .o_any_c   (w_any)
  );

  // Pointer after the current owner, so the finished owner has lowest priority next.
  always_comb begin
    w_ptr_next = (r_grant == PTR_MAX) ? '0 : r_grant + IDX_W'(1);
  end

  // Byte lane of the current owner.
  always_comb begin
    w_sel_byte = bus.req_data[BYTE_W*int'(r_grant) +: BYTE_W];
  end

  // Sequencer: grant, accept a byte, run the start/ready handshake, hold the grant until last.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_byte      <= '0;
      r_last      <= 1'b0;
      r_wd        <= '0;
      r_req_ready <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_busy      <= 1'b1;
            r_req_ready <= ONE << w_pick;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_byte  <= w_sel_byte;
          r_last  <= bus.req_last[r_grant];
          r_start <= 1'b1;
          r_wd    <= '0;
          r_state <= ST_START;
        end
        ST_START: begin
          if (!bus.uart_tx_ready) begin
            r_start <= 1'b0;
            r_state <= ST_SEND;
          end else if (r_wd == WD_LAST) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_rr_ptr  <= w_ptr_next;
            r_state   <= ST_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_SEND: begin
          if (bus.uart_tx_ready) begin
            if (r_last) begin
              r_busy   <= 1'b0;
              r_rr_ptr <= w_ptr_next;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.req_valid[r_grant]) begin
            r_req_ready <= ONE << r_grant;
            r_state     <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready          = r_req_ready;
  assign bus.uart_tx_start      = r_start;
  assign bus.uart_transmit_data = r_byte;
  assign grant_id               = r_grant;
  assign busy                   = r_busy;
  assign timeout_err            = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART and a transmit scoreboard.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ACK_TIMEOUT = 64;
  localparam int unsigned IDX_W       = 2;
  localparam int          BYTE_CYC    = 10 * int'(UART_CLOCK_FREQ / UART_BAUD_RATE);
  localparam int          RX_WAIT     = 2000;

  logic             clk_10ns   = 1'b0;
  logic             uart_reset = 1'b0;
  logic [IDX_W-1:0] grant_id;
  logic             busy;
  logic             timeout_err;

  // Bench-side drivers of the interface inputs.
  logic [NUM_REQ-1:0]        valid_m = '0;
  logic [NUM_REQ*BYTE_W-1:0] data_m  = '0;
  logic [NUM_REQ-1:0]        last_m  = '0;
  logic                      ready_m = 1'b1;
  logic                      stuck   = 1'b0;

  int tests  = 0;
  int failed = 0;

  // Requester streams {last, data}; the driver advances rd_idx, the initial block only appends.
  logic [8:0] rq [NUM_REQ][$];
  int         rd_idx [NUM_REQ];
  logic [NUM_REQ-1:0] pop_pend = '0;

  // Scoreboard: expected {grant, byte} and bytes observed at the UART.
  logic [9:0] exp_q [$];
  logic [9:0] obs_q [$];
  int         obs_rd = 0;
  int         viol   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  assign bus.req_valid     = valid_m;
  assign bus.req_data      = data_m;
  assign bus.req_last      = last_m;
  assign bus.uart_tx_ready = ready_m;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_10ns    (clk_10ns),
    .uart_reset  (uart_reset),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_10ns = ~clk_10ns;

  // Requesters: present the head byte; retire it one cycle after its ready pulse.
  always @(negedge clk_10ns) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      logic [8:0] h;
      if (pop_pend[i]) rd_idx[i] = rd_idx[i] + 1;
      pop_pend[i] = bus.req_ready[i];
      if (rd_idx[i] < rq[i].size()) begin
        h = rq[i][rd_idx[i]];
        valid_m[i]          = 1'b1;
        data_m[8*i +: 8]    = h[7:0];
        last_m[i]           = h[8];
      end else begin
        valid_m[i] = 1'b0;
        last_m[i]  = 1'b0;
      end
    end
  end

  // UART model: accept start by dropping ready, stay busy for one character time.
  int   u_cnt  = 0;
  logic u_busy = 1'b0;
  always @(negedge clk_10ns) begin
    if (!uart_reset) begin
      ready_m = 1'b1;
      u_busy  = 1'b0;
      u_cnt   = 0;
    end else if (stuck) begin
      ready_m = 1'b1;
    end else if (!u_busy) begin
      if (bus.uart_tx_start) begin
        obs_q.push_back({grant_id, bus.uart_transmit_data});
        ready_m = 1'b0;
        u_busy  = 1'b1;
        u_cnt   = BYTE_CYC;
      end
    end else begin
      if (bus.uart_tx_start) viol = viol + 1;
      u_cnt = u_cnt - 1;
      if (u_cnt == 0) begin
        ready_m = 1'b1;
        u_busy  = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [7:0] b, input logic last, input bit exp);
    rq[id].push_back({last, b});
    if (exp) exp_q.push_back({IDX_W'(id), b});
  endtask

  task automatic expect_rx(input string tag);
    logic [9:0] e;
    int n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (obs_q.size() <= obs_rd && n < RX_WAIT) begin
        @(posedge clk_10ns);
        n++;
      end
      if (obs_q.size() > obs_rd) begin
        check(tag, 32'(obs_q[obs_rd]), 32'(e));
        obs_rd++;
      end else begin
        check({tag, "_timeout"}, 32'(obs_q.size()), 32'(obs_rd + 1));
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #1;
    while (busy && n < 3000) begin
      @(posedge clk_10ns);
      #1;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk_10ns);
    #2 uart_reset = 1'b0;
    repeat (3) @(posedge clk_10ns);
    #2 uart_reset = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"},   32'(bus.uart_tx_start), 32'd0);
    check({tag, "_data"},    32'(bus.uart_transmit_data), 32'd0);
    check({tag, "_rdy"},     32'(bus.req_ready), 32'd0);
    check({tag, "_grant"},   32'(grant_id), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int   n;
    logic stall_ok;

    for (int i = 0; i < int'(NUM_REQ); i++) rd_idx[i] = 0;

    // Reset state.
    repeat (3) @(posedge clk_10ns);
    #1 check_outputs_zero("reset");
    #1 uart_reset = 1'b1;

    // Single-byte frame and start latency.
    @(posedge clk_10ns);
    #2 send(0, 8'h02, 1'b1, 1'b1);
    @(negedge clk_10ns);
    #1;
    n = 0;
    do begin
      @(posedge clk_10ns);
      #1;
      n++;
    end while (!bus.uart_tx_start && n < 20);
    check("start_latency", 32'(n), 32'd2);
    expect_rx("single_rx");
    wait_idle("single_idle");
    check("single_grant", 32'(grant_id), 32'd0);

    // Multi-byte frame is not interrupted by another valid requester.
    do_reset();
    send(1, 8'h0A, 1'b0, 1'b1);
    send(1, 8'h0B, 1'b0, 1'b1);
    send(1, 8'h0C, 1'b1, 1'b1);
    send(2, 8'h55, 1'b1, 1'b1);
    expect_rx("multi_rx");
    wait_idle("multi_idle");

    // Round-robin fairness with all requesters valid.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(NUM_REQ); i++)
        send(i, 8'h10 + 8'(i), 1'b1, 1'b1);
    expect_rx("rr_rx");
    wait_idle("rr_idle");

    // Watchdog: move pointer to 2, then requester 3 times out.
    send(1, 8'h21, 1'b1, 1'b1);
    expect_rx("pre_wd_rx");
    wait_idle("pre_wd_idle");
    stuck = 1'b1;
    send(3, 8'hFF, 1'b1, 1'b0);
    n = 0;
    do begin
      @(posedge clk_10ns);
      #1;
      n++;
    end while (!bus.uart_tx_start && n < 20);
    n = 0;
    while (bus.uart_tx_start && n < 200) begin
      @(posedge clk_10ns);
      #1;
      n++;
    end
    check("wd_start_cycles", 32'(n), 32'(ACK_TIMEOUT));
    check("wd_timeout_err", 32'(timeout_err), 32'd1);
    check("wd_busy", 32'(busy), 32'd0);
    stuck = 1'b0;
    repeat (2) @(posedge clk_10ns);
    #2;
    send(2, 8'h42, 1'b1, 1'b0);
    send(0, 8'h40, 1'b1, 1'b0);
    exp_q.push_back({2'd0, 8'h40});
    exp_q.push_back({2'd2, 8'h42});
    expect_rx("wd_next_rx");
    wait_idle("wd_next_idle");
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // HOLD stall: owner drops valid mid-frame, others stay blocked.
    send(0, 8'h31, 1'b0, 1'b1);
    expect_rx("hold_first_rx");
    send(1, 8'h77, 1'b1, 1'b0);
    stall_ok = 1'b1;
    repeat (500) begin
      @(posedge clk_10ns);
      #1;
      if (!busy || grant_id != 2'd0 || obs_q.size() != obs_rd) stall_ok = 1'b0;
    end
    check("hold_stall", 32'(stall_ok), 32'd1);
    send(0, 8'h30, 1'b1, 1'b1);
    exp_q.push_back({2'd1, 8'h77});
    expect_rx("hold_rx");
    wait_idle("hold_idle");

    // Reset during SEND with the pointer at 2 and timeout_err still set.
    send(2, 8'hA5, 1'b1, 1'b1);
    expect_rx("rst_rx");
    repeat (5) @(posedge clk_10ns);
    #2 uart_reset = 1'b0;
    #1 check_outputs_zero("async_rst");
    repeat (3) @(posedge clk_10ns);
    #2 uart_reset = 1'b1;
    #1 check("rst_timeout_clr", 32'(timeout_err), 32'd0);
    send(1, 8'h61, 1'b1, 1'b0);
    send(0, 8'h60, 1'b1, 1'b0);
    exp_q.push_back({2'd0, 8'h60});
    exp_q.push_back({2'd1, 8'h61});
    expect_rx("post_rst_rx");
    wait_idle("post_rst_idle");

    check("start_while_busy", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter in uart_rx_tx between NUM_REQ byte-stream requesters.
- Grants are round-robin at frame granularity: a granted requester keeps the transmitter until its byte tagged last has been sent.
- The block sequences the transmitter's start/ready handshake: it asserts start, waits for ready to fall, then waits for ready to rise.
- A start-acknowledge watchdog aborts a frame if the transmitter never accepts a byte.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 64, clock cycles to wait for uart_tx_ready to fall after start before aborting.
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden).

Ports:
- clk_10ns  in  1  system clock.
- uart_reset  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its frame.
- req_ready  out  NUM_REQ  one-hot, single-cycle byte-accept pulse.
- uart_tx_start  out  1  transmit request to the UART.
- uart_transmit_data  out  8  byte presented to the UART.
- uart_tx_ready  in  1  UART idle; low while transmitting.
- grant_id  out  IDX_W  current owner; valid while busy=1.
- busy  out  1  a frame is in progress.
- timeout_err  out  1  sticky; set on watchdog abort.

Behaviour:
- Reset (uart_reset=0, asynchronous): every output is 0, the round-robin pointer is 0, and state=IDLE.
- States and transitions:
  - IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward with wrap; go to LOAD.
  - LOAD: capture req_data[grant], capture req_last[grant], pulse req_ready[grant] for 1 cycle; go to START. Acceptance is req_valid&req_ready in this cycle.
  - START: uart_tx_start=1, uart_transmit_data=captured byte (held stable). When uart_tx_ready=0, drop start; go to SEND. If the watchdog reaches ACK_TIMEOUT-1, set timeout_err, drop start, abort the frame; go to IDLE with rr_ptr=grant+1 (mod NUM_REQ).
  - SEND: wait for uart_tx_ready=1. Then if captured last=1: rr_ptr=grant+1 mod NUM_REQ, go to IDLE. Otherwise go to HOLD.
  - HOLD: wait for req_valid[grant] with no timeout; other requesters stay blocked. When it is seen, go to LOAD with the same grant.
- Latency: IDLE with valid to uart_tx_start=1 is 2 cycles (IDLE→LOAD→START). Minimum inter-byte gap after uart_tx_ready rises is 3 cycles (SEND→HOLD→LOAD→START).
- busy=1 in every state except IDLE. grant_id is registered in IDLE and is stable for the whole frame.
- uart_tx_start must never be asserted while uart_tx_ready=0 in START entry. START is entered only from LOAD, after SEND has confirmed ready=1.
- Simultaneous requests are resolved by round-robin. The owner of the frame just finished has lowest priority for the next grant.
- rr_ptr wraps at NUM_REQ. NUM_REQ need not be a power of two.
- A requester deasserting valid mid-frame is legal; the block holds in HOLD.
- timeout_err is cleared only by reset.
- Reset asserted mid-byte: uart_tx_start drops immediately and the frame is discarded. The UART is reset by the same signal.

Decomposition:
- Package uart_pkg holds:
  - the state enum type (IDLE, LOAD, START, SEND, HOLD);
  - the default constants UART_BAUD_RATE=1500000 and UART_CLOCK_FREQ=10000000;
  - the byte width constant 8.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the req vector and rr_ptr; outputs are grant index and any_req. It is reused by future receive-side routing.

Test Plan:
- Single-byte frame: requester 0 sends 8'h02 with last=1, arbiter driving uart_rx_tx in loopback. Expected: uart_tx_start 2 cycles after valid; loopback receives 02; busy returns to 0; grant_id=0.
- Multi-byte frame: requester 1 sends 8'h0A,8'h0B,8'h0C (last on 0C) while requester 2 is valid throughout with 8'h55. Expected: receive order 0A,0B,0C,55; requester 2 is never granted mid-frame.
- Round-robin fairness: all 4 requesters are valid, each sending one single-byte frame (8'h10+i), repeated twice. Expected: grant order 0,1,2,3,0,1,2,3.
- Watchdog: uart_tx_ready is forced to 1 permanently and requester 3 sends 8'hFF. Expected: start held exactly 64 cycles, then timeout_err=1 and busy=0; the next grant goes to requester 0.
- HOLD stall: requester 0 sends 8'h31 (last=0), then drops valid for 500 cycles, then sends 8'h30 (last=1). Expected: busy stays 1, no other grant in between, received bytes are 31,30.
- Reset mid-transmission: uart_reset is pulsed low during SEND of 8'hA5. Expected: all outputs are 0 asynchronously; after release, state=IDLE, rr_ptr=0, timeout_err=0.
